// File: rtl/transceiver_frame_tx.sv
// Tx frame builder: wraps ACK/NACK DLLPs and streamed TLP payloads into {k, byte} symbols
// with start/end K-codes and CRC-16, emitting idle K-codes between frames.
`ifndef K_CODE_START_DLLP
`define K_CODE_START_DLLP 8'h5C
`endif
`ifndef K_CODE_START_TLP
`define K_CODE_START_TLP 8'hFB
`endif

module transceiver_frame_tx #(
    parameter logic [7:0] K_START_DLLP = `K_CODE_START_DLLP,
    parameter logic [7:0] K_START_TLP  = `K_CODE_START_TLP,
    parameter logic [7:0] K_END        = 8'hFD,
    parameter logic [7:0] K_IDLE       = 8'hBC,
    parameter int         MAX_TLP_LEN  = 64
) (
    input  logic       i_sys_clk_120,
    input  logic       i_sys_arst_n,
    input  logic       i_link_up,
    input  logic       i_dllp_req,
    input  logic       i_dllp_ack,
    input  logic [7:0] i_dllp_seq,
    output logic       o_dllp_pending,
    input  logic       i_tlp_valid,
    input  logic [7:0] i_tlp_data,
    input  logic       i_tlp_last,
    input  logic [7:0] i_tlp_seq,
    output logic       o_tlp_ready,
    output logic       o_tlp_trunc,
    output logic [8:0] o_data,
    output logic [3:0] o_dbg_state
);

    // Payload handshake: a byte transfers on a rising edge where i_tlp_valid && o_tlp_ready;
    // ready depends only on FSM state and i_link_up, never on valid.
    typedef enum logic [3:0] {
        IDLE, D_TYPE, D_SEQ, T_SEQ, T_PAY, T_DROP, CRC_HI, CRC_LO, END
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(MAX_TLP_LEN - 1);

    state_t      state, state_nxt;
    logic [8:0]  sym_nxt;
    logic [15:0] crc, crc_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        pend, pend_ack, frm_ack, drop_q, gap_q;
    logic [7:0]  pend_seq, frm_seq;
    logic        start_dllp, start_tlp, accept, cap_hit;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign o_tlp_ready    = i_link_up && (state == T_PAY || state == T_DROP);
    assign accept         = o_tlp_ready && i_tlp_valid;
    // gap_q blocks a start on the cycle right after END so frames are always idle-separated.
    assign start_dllp     = i_link_up && state == IDLE && !gap_q && pend;
    assign start_tlp      = i_link_up && state == IDLE && !gap_q && !pend && i_tlp_valid;
    assign cap_hit        = accept && state == T_PAY && !i_tlp_last && cnt == LAST_IDX;
    assign o_dllp_pending = pend;
    assign o_dbg_state    = state;

    always_comb begin
        state_nxt = state;
        sym_nxt   = {1'b1, K_IDLE};
        crc_nxt   = crc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start_dllp) begin
                    sym_nxt   = {1'b1, K_START_DLLP};
                    crc_nxt   = 16'hFFFF;
                    state_nxt = D_TYPE;
                end else if (start_tlp) begin
                    sym_nxt   = {1'b1, K_START_TLP};
                    crc_nxt   = 16'hFFFF;
                    cnt_nxt   = 8'd0;
                    state_nxt = T_SEQ;
                end
            end
            D_TYPE: begin
                sym_nxt   = {1'b0, frm_ack, 7'b0};
                crc_nxt   = crc16_byte(crc, {frm_ack, 7'b0});
                state_nxt = D_SEQ;
            end
            D_SEQ, T_SEQ: begin
                sym_nxt   = {1'b0, frm_seq};
                crc_nxt   = crc16_byte(crc, frm_seq);
                state_nxt = (state == D_SEQ) ? CRC_HI : T_PAY;
            end
            T_PAY: begin
                if (accept) begin
                    sym_nxt = {1'b0, i_tlp_data};
                    crc_nxt = crc16_byte(crc, i_tlp_data);
                    cnt_nxt = cnt + 8'd1;
                    if (i_tlp_last || cnt == LAST_IDX) state_nxt = CRC_HI;
                end
            end
            T_DROP: begin
                if (accept && i_tlp_last) state_nxt = IDLE;
            end
            CRC_HI: begin
                sym_nxt   = {1'b0, crc[15:8]};
                state_nxt = CRC_LO;
            end
            CRC_LO: begin
                sym_nxt   = {1'b0, crc[7:0]};
                state_nxt = END;
            end
            END: begin
                sym_nxt   = {1'b1, K_END};
                state_nxt = drop_q ? T_DROP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Link loss aborts any frame without K_END.
        if (!i_link_up) begin
            state_nxt = IDLE;
            sym_nxt   = {1'b1, K_IDLE};
        end
    end

    always_ff @(posedge i_sys_clk_120 or negedge i_sys_arst_n) begin
        if (!i_sys_arst_n) begin
            state       <= IDLE;
            o_data      <= {1'b1, K_IDLE};
            crc         <= 16'hFFFF;
            cnt         <= 8'd0;
            pend        <= 1'b0;
            pend_ack    <= 1'b0;
            pend_seq    <= 8'd0;
            frm_ack     <= 1'b0;
            frm_seq     <= 8'd0;
            drop_q      <= 1'b0;
            gap_q       <= 1'b0;
            o_tlp_trunc <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_data      <= sym_nxt;
            crc         <= crc_nxt;
            cnt         <= cnt_nxt;
            o_tlp_trunc <= cap_hit;
            gap_q       <= i_link_up && state == END;
            // A request coinciding with a start decision re-arms pending with the new values.
            if (!i_link_up) begin
                pend <= 1'b0;
            end else if (i_dllp_req) begin
                pend     <= 1'b1;
                pend_ack <= i_dllp_ack;
                pend_seq <= i_dllp_seq;
            end else if (start_dllp) begin
                pend <= 1'b0;
            end
            if (start_dllp) begin
                frm_ack <= pend_ack;
                frm_seq <= pend_seq;
            end else if (start_tlp) begin
                frm_seq <= i_tlp_seq;
            end
            if (!i_link_up)        drop_q <= 1'b0;
            else if (cap_hit)      drop_q <= 1'b1;
            else if (state == END) drop_q <= 1'b0;
        end
    end

endmodule
